// File: rtl/tlb_manager_pkg.sv
// Shared MMU types for the TLB manager: entry layout, TLB op encodings, FSM states.
// The optional TLB_PARALLEL_PROBE_EN macro is consumed by tlb_manager.sv.
package tlb_manager_pkg;

    localparam int VPN2_W = 19;
    localparam int ASID_W = 8;
    localparam int PFN_W  = 20;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [VPN2_W-1:0] mask;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PFN_W-1:0]  pfn0;
        logic [4:0]        flags0;
        logic [PFN_W-1:0]  pfn1;
        logic [4:0]        flags1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        TLB_OP_TLBR  = 2'd0,
        TLB_OP_TLBWI = 2'd1,
        TLB_OP_TLBWR = 2'd2,
        TLB_OP_TLBP  = 2'd3
    } tlb_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_RESP  = 2'd2
    } tlb_state_t;

    // Saturate an index value to the last valid entry.
    function automatic int unsigned clamp_index(input int unsigned value,
                                                input int unsigned n_entries);
        return (value > n_entries - 1) ? n_entries - 1 : value;
    endfunction

endpackage

// File: rtl/tlb_manager_if.sv
// Request/response and status bundle between the TLB manager and its client.
interface tlb_manager_if #(
    parameter int N_TLB_ENTRIES = 32
);
    import tlb_manager_pkg::*;

    localparam int IW = $clog2(N_TLB_ENTRIES);

    logic                            req_valid;
    tlb_op_t                         req_op;
    logic                            req_ready;
    logic [IW-1:0]                   req_index;
    tlb_entry_t                      req_entry;
    logic                            wired_we;
    logic [IW-1:0]                   wired_wdata;
    logic                            resp_valid;
    tlb_entry_t                      resp_entry;
    logic [IW-1:0]                   resp_index;
    logic                            resp_probe_miss;
    tlb_entry_t [N_TLB_ENTRIES-1:0]  entries;
    logic [IW-1:0]                   random;

    modport master (
        output req_valid, req_op, req_index, req_entry, wired_we, wired_wdata,
        input  req_ready, resp_valid, resp_entry, resp_index, resp_probe_miss,
               entries, random
    );

    modport slave (
        input  req_valid, req_op, req_index, req_entry, wired_we, wired_wdata,
        output req_ready, resp_valid, resp_entry, resp_index, resp_probe_miss,
               entries, random
    );

endinterface

// File: rtl/tlb_manager_entry_match.sv
// Single TLB entry compare against a probe key (masked VPN2 plus ASID or global).
module tlb_entry_match
    import tlb_manager_pkg::*;
(
    input  logic [VPN2_W-1:0] key_vpn2,
    input  logic [ASID_W-1:0] key_asid,
    input  logic [VPN2_W-1:0] entry_vpn2,
    input  logic [VPN2_W-1:0] entry_mask,
    input  logic [ASID_W-1:0] entry_asid,
    input  logic              entry_g,
    output logic              match
);

    logic vpn_hit;
    logic asid_hit;

    assign vpn_hit  = ((key_vpn2 & ~entry_mask) == (entry_vpn2 & ~entry_mask));
    assign asid_hit = entry_g || (entry_asid == key_asid);
    assign match    = vpn_hit && asid_hit;

endmodule

// File: rtl/tlb_manager.sv
// TLB management engine: TLBR/TLBWI/TLBWR/TLBP, Random/Wired registers, entry array.
// Define TLB_PARALLEL_PROBE_EN for a single-cycle all-entry probe; default is a serial scan.
module tlb_manager
    import tlb_manager_pkg::*;
#(
    parameter int N_TLB_ENTRIES = 32
) (
    input  logic          clk,
    input  logic          rst,
    tlb_manager_if.slave  bus
);

    localparam int            IW         = $clog2(N_TLB_ENTRIES);
    localparam logic [IW-1:0] LAST_INDEX = IW'(N_TLB_ENTRIES - 1);

    tlb_state_t                     state_reg, state_next;
    tlb_entry_t [N_TLB_ENTRIES-1:0] entries_reg;
    logic [IW-1:0]                  random_reg, random_next;
    logic [IW-1:0]                  wired_reg, wired_next;
    tlb_entry_t                     resp_entry_reg, resp_entry_next;
    logic [IW-1:0]                  resp_index_reg, resp_index_next;
    logic                           resp_miss_reg, resp_miss_next;

    logic          accept;
    logic          write_en;
    logic [IW-1:0] write_index;

    assign accept      = bus.req_valid && (state_reg == ST_IDLE);
    assign write_en    = accept && ((bus.req_op == TLB_OP_TLBWI) || (bus.req_op == TLB_OP_TLBWR));
    // TLBWR always uses the Random value seen in the accept cycle, even if Wired is written then.
    assign write_index = (bus.req_op == TLB_OP_TLBWR) ? random_reg : bus.req_index;

    always_comb begin
        wired_next  = wired_reg;
        random_next = random_reg - 1'b1;
        if (bus.wired_we) begin
            wired_next  = IW'(clamp_index(32'(bus.wired_wdata), N_TLB_ENTRIES));
            random_next = LAST_INDEX;
        end else if (random_reg == wired_reg) begin
            random_next = LAST_INDEX;
        end
    end

`ifdef TLB_PARALLEL_PROBE_EN
    logic [N_TLB_ENTRIES-1:0] hit_vec;
    logic                     par_hit;
    logic [IW-1:0]            par_index;

    genvar gi;
    generate
        for (gi = 0; gi < N_TLB_ENTRIES; gi++) begin : g_match
            tlb_entry_match u_match (
                .key_vpn2   (bus.req_entry.vpn2),
                .key_asid   (bus.req_entry.asid),
                .entry_vpn2 (entries_reg[gi].vpn2),
                .entry_mask (entries_reg[gi].mask),
                .entry_asid (entries_reg[gi].asid),
                .entry_g    (entries_reg[gi].g),
                .match      (hit_vec[gi])
            );
        end
    endgenerate

    // Walk downwards so the lowest matching index wins.
    always_comb begin
        par_hit   = 1'b0;
        par_index = '0;
        for (int i = N_TLB_ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                par_hit   = 1'b1;
                par_index = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0]     scan_reg, scan_next;
    logic [VPN2_W-1:0] key_vpn2_reg, key_vpn2_next;
    logic [ASID_W-1:0] key_asid_reg, key_asid_next;
    logic              scan_hit;

    tlb_entry_match u_match (
        .key_vpn2   (key_vpn2_reg),
        .key_asid   (key_asid_reg),
        .entry_vpn2 (entries_reg[scan_reg].vpn2),
        .entry_mask (entries_reg[scan_reg].mask),
        .entry_asid (entries_reg[scan_reg].asid),
        .entry_g    (entries_reg[scan_reg].g),
        .match      (scan_hit)
    );
`endif

    always_comb begin
        state_next      = state_reg;
        resp_entry_next = resp_entry_reg;
        resp_index_next = resp_index_reg;
        resp_miss_next  = resp_miss_reg;
`ifndef TLB_PARALLEL_PROBE_EN
        scan_next       = scan_reg;
        key_vpn2_next   = key_vpn2_reg;
        key_asid_next   = key_asid_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_next = ST_RESP;
                    case (bus.req_op)
                        TLB_OP_TLBR: resp_entry_next = entries_reg[bus.req_index];
                        TLB_OP_TLBP: begin
`ifdef TLB_PARALLEL_PROBE_EN
                            resp_index_next = par_hit ? par_index : '0;
                            resp_miss_next  = !par_hit;
`else
                            state_next    = ST_PROBE;
                            scan_next     = '0;
                            key_vpn2_next = bus.req_entry.vpn2;
                            key_asid_next = bus.req_entry.asid;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_PROBE: begin
`ifdef TLB_PARALLEL_PROBE_EN
                state_next = ST_IDLE;
`else
                if (scan_hit) begin
                    resp_index_next = scan_reg;
                    resp_miss_next  = 1'b0;
                    state_next      = ST_RESP;
                end else if (scan_reg == LAST_INDEX) begin
                    resp_index_next = '0;
                    resp_miss_next  = 1'b1;
                    state_next      = ST_RESP;
                end else begin
                    scan_next = scan_reg + 1'b1;
                end
`endif
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            entries_reg    <= '0;
            random_reg     <= LAST_INDEX;
            wired_reg      <= '0;
            resp_entry_reg <= '0;
            resp_index_reg <= '0;
            resp_miss_reg  <= 1'b0;
`ifndef TLB_PARALLEL_PROBE_EN
            scan_reg       <= '0;
            key_vpn2_reg   <= '0;
            key_asid_reg   <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            random_reg     <= random_next;
            wired_reg      <= wired_next;
            resp_entry_reg <= resp_entry_next;
            resp_index_reg <= resp_index_next;
            resp_miss_reg  <= resp_miss_next;
`ifndef TLB_PARALLEL_PROBE_EN
            scan_reg       <= scan_next;
            key_vpn2_reg   <= key_vpn2_next;
            key_asid_reg   <= key_asid_next;
`endif
            if (write_en) begin
                entries_reg[write_index] <= bus.req_entry;
            end
        end
    end

    assign bus.req_ready       = (state_reg == ST_IDLE);
    assign bus.resp_valid      = (state_reg == ST_RESP);
    assign bus.resp_entry      = resp_entry_reg;
    assign bus.resp_index      = resp_index_reg;
    assign bus.resp_probe_miss = resp_miss_reg;
    assign bus.entries         = entries_reg;
    assign bus.random          = random_reg;

endmodule

// File: tb/tb_tlb_manager.sv
// Directed-vector bench for tlb_manager (N=32), one line per miscompare plus a summary.
module tb_tlb_manager;
    import tlb_manager_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_vectors     = 0;
    int   n_miscompares = 0;

    tlb_manager_if #(.N_TLB_ENTRIES(N)) bus ();

    tlb_manager #(.N_TLB_ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic tlb_entry_t mk_entry(input logic [18:0] vpn2, input logic [18:0] mask,
                                            input logic [7:0] asid, input logic g,
                                            input logic [19:0] pfn0);
        tlb_entry_t e;
        e        = '0;
        e.vpn2   = vpn2;
        e.mask   = mask;
        e.asid   = asid;
        e.g      = g;
        e.pfn0   = pfn0;
        e.flags0 = 5'h1f;
        e.pfn1   = pfn0 + 20'd1;
        e.flags1 = 5'h0a;
        return e;
    endfunction

    // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle again.
    task automatic do_req(input tlb_op_t op, input logic [4:0] idx, input tlb_entry_t e,
                          output int lat, output tlb_entry_t r_entry,
                          output logic [4:0] r_index, output logic r_miss);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_index = idx;
        bus.req_entry = e;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.resp_valid) check_eq("resp_timeout", 0, 1);
        r_entry = bus.resp_entry;
        r_index = bus.resp_index;
        r_miss  = bus.resp_probe_miss;
        @(negedge clk);
        check_eq("resp_one_cycle", bus.resp_valid, 1'b0);
        check_eq("ready_after_resp", bus.req_ready, 1'b1);
    endtask

    tlb_entry_t e5, e2, e9, ew, key_hit, key_miss, key_two, key_g, r_entry;
    logic [4:0] r_index;
    logic       r_miss;
    int         lat, exp_r, found;
    int         exp_probe5_lat, exp_miss_lat, exp_two_lat, exp_g_lat;

    initial begin
        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_op      = TLB_OP_TLBR;
        bus.req_index   = '0;
        bus.req_entry   = '0;
        bus.wired_we    = 1'b0;
        bus.wired_wdata = '0;

        e5       = mk_entry(19'h12345, 19'h0, 8'd3, 1'b0, 20'habcde);
        e2       = mk_entry(19'h00ab0, 19'h0000f, 8'd7, 1'b0, 20'h11111);
        e9       = mk_entry(19'h00ab5, 19'h000ff, 8'd9, 1'b1, 20'h22222);
        ew       = mk_entry(19'h7f000, 19'h0, 8'd1, 1'b0, 20'h33333);
        key_hit  = mk_entry(19'h12345, 19'h0, 8'd3, 1'b0, 20'h0);
        key_miss = mk_entry(19'h12345, 19'h0, 8'd4, 1'b0, 20'h0);
        key_two  = mk_entry(19'h00ab7, 19'h0, 8'd7, 1'b0, 20'h0);
        key_g    = mk_entry(19'h00a12, 19'h0, 8'h55, 1'b0, 20'h0);

`ifdef TLB_PARALLEL_PROBE_EN
        exp_probe5_lat = 1;  exp_miss_lat = 1;  exp_two_lat = 1;  exp_g_lat = 1;
`else
        exp_probe5_lat = 7;  exp_miss_lat = N + 1;  exp_two_lat = 4;  exp_g_lat = 11;
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_random", bus.random, 5'd31);
        check_eq("rst_ready", bus.req_ready, 1'b1);
        check_eq("rst_resp_valid", bus.resp_valid, 1'b0);
        check_eq("rst_resp_entry", bus.resp_entry, 0);
        check_eq("rst_resp_index", bus.resp_index, 0);
        check_eq("rst_resp_miss", bus.resp_probe_miss, 1'b0);
        check_eq("rst_entry5", bus.entries[5], 0);

        // Random counts 31 down to 0 with wired=0, then wraps to 31.
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            exp_r = (k <= 31) ? 31 - k : 31;
            check_eq("random_count", bus.random, exp_r[4:0]);
        end

        do_req(TLB_OP_TLBWI, 5'd5, e5, lat, r_entry, r_index, r_miss);
        check_eq("tlbwi_lat", lat, 1);
        check_eq("tlbwi_entry5", bus.entries[5], e5);

        do_req(TLB_OP_TLBR, 5'd5, '0, lat, r_entry, r_index, r_miss);
        check_eq("tlbr_lat", lat, 1);
        check_eq("tlbr_entry", r_entry, e5);

        do_req(TLB_OP_TLBP, 5'd0, key_hit, lat, r_entry, r_index, r_miss);
        check_eq("tlbp_hit_lat", lat, exp_probe5_lat);
        check_eq("tlbp_hit_index", r_index, 5'd5);
        check_eq("tlbp_hit_miss", r_miss, 1'b0);
        check_eq("resp_entry_hold", bus.resp_entry, e5);

        do_req(TLB_OP_TLBP, 5'd0, key_miss, lat, r_entry, r_index, r_miss);
        check_eq("tlbp_miss_lat", lat, exp_miss_lat);
        check_eq("tlbp_miss_flag", r_miss, 1'b1);
        check_eq("tlbp_miss_index", r_index, 5'd0);

        do_req(TLB_OP_TLBWI, 5'd2, e2, lat, r_entry, r_index, r_miss);
        do_req(TLB_OP_TLBWI, 5'd9, e9, lat, r_entry, r_index, r_miss);
        do_req(TLB_OP_TLBP, 5'd0, key_two, lat, r_entry, r_index, r_miss);
        check_eq("tlbp_two_lat", lat, exp_two_lat);
        check_eq("tlbp_two_index", r_index, 5'd2);
        check_eq("tlbp_two_miss", r_miss, 1'b0);

        do_req(TLB_OP_TLBP, 5'd0, key_g, lat, r_entry, r_index, r_miss);
        check_eq("tlbp_global_lat", lat, exp_g_lat);
        check_eq("tlbp_global_index", r_index, 5'd9);
        check_eq("tlbp_global_miss", r_miss, 1'b0);

        // Wired write together with TLBWR while Random is 20.
        found = 0;
        for (int k = 0; k < 64 && found == 0; k++) begin
            if (bus.random == 5'd20) found = 1;
            else @(negedge clk);
        end
        check_eq("random_reach_20", found, 1);
        bus.req_valid   = 1'b1;
        bus.req_op      = TLB_OP_TLBWR;
        bus.req_index   = 5'd5;
        bus.req_entry   = ew;
        bus.wired_we    = 1'b1;
        bus.wired_wdata = 5'd8;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.wired_we  = 1'b0;
        check_eq("tlbwr_resp", bus.resp_valid, 1'b1);
        check_eq("tlbwr_entry20", bus.entries[20], ew);
        check_eq("tlbwr_entry5_kept", bus.entries[5], e5);
        check_eq("wired_random_reload", bus.random, 5'd31);
        exp_r = 31;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_r = (exp_r == 8) ? 31 : exp_r - 1;
            check_eq("random_wired", bus.random, exp_r[4:0]);
            check_eq("random_floor", bus.random >= 5'd8, 1'b1);
        end

`ifndef TLB_PARALLEL_PROBE_EN
        // Serial probe aborted by reset while scanning index 10.
        bus.req_valid = 1'b1;
        bus.req_op    = TLB_OP_TLBP;
        bus.req_entry = key_miss;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("probe_no_resp", bus.resp_valid, 1'b0);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_no_resp", bus.resp_valid, 1'b0);
        rst = 1'b0;
        check_eq("abort_ready", bus.req_ready, 1'b1);
        check_eq("abort_entry5_clr", bus.entries[5], 0);
        check_eq("abort_random", bus.random, 5'd31);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            check_eq("abort_quiet", bus.resp_valid, 1'b0);
        end
        check_eq("wired_cleared", bus.random, 5'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/tlb_manager.md
TLB_MANAGER -- requirements
Module: tlb_manager

Interface
REQ-001 SHALL have parameter N_TLB_ENTRIES, default 32, number of TLB entries (power of two, 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  TLB management request present.
REQ-005 SHALL have port req_op  input  2  operation: 0 TLBR, 1 TLBWI, 2 TLBWR, 3 TLBP.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-007 SHALL have port req_index  input  clog2(N)  Index register value for TLBR/TLBWI.
REQ-008 SHALL have port req_entry  input  tlb_entry_t  entry data for TLBWI/TLBWR; vpn2, mask and asid fields used as TLBP key.
REQ-009 SHALL have port wired_we, wired_wdata  input  1, clog2(N)  Wired register write.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_entry, resp_index, resp_probe_miss  output  tlb_entry_t, clog2(N), 1  TLBR data, TLBP result.
REQ-012 SHALL have port entries  output  tlb_entry_t[N-1:0]  registered entry array feeding the lookup blocks.
REQ-013 SHALL have port random  output  clog2(N)  current Random register.

Function
REQ-014 SHALL implement FSM states IDLE, PROBE, RESP; req_ready high only in IDLE.
REQ-015 SHALL, on accepted TLBWI, write req_entry to entries[req_index] at the accept edge, then go to RESP.
REQ-016 SHALL, on accepted TLBWR, write req_entry to entries[random] using the random value in the accept cycle, then go to RESP.
REQ-017 SHALL, on accepted TLBR, capture entries[req_index] into resp_entry at the accept edge, then go to RESP.
REQ-018 SHALL, in RESP, assert resp_valid for exactly one cycle and return to IDLE; TLBR/TLBWI/TLBWR latency is one cycle from accept.
REQ-019 SHALL define a TLBP match for entry i as (key.vpn2 & ~entries[i].mask) == (entries[i].vpn2 & ~entries[i].mask) and (entries[i].G or entries[i].asid == key.asid); the key is latched at accept.
REQ-020 SHALL report the lowest matching index in resp_index with resp_probe_miss=0; on no match, resp_probe_miss=1 and resp_index=0.
REQ-021 SHALL decrement random every cycle; when random equals wired, the next value is N-1.
REQ-022 SHALL, on wired_we, load wired with wired_wdata and set random to N-1 at the same edge; a TLBWR accepted in that same cycle uses the pre-update random.
REQ-023 SHALL clamp wired_wdata to N-1 if it is out of range; with wired == N-1, random stays N-1.
REQ-024 SHALL hold resp_entry, resp_index and resp_probe_miss stable until the next resp_valid.
REQ-025 SHALL make a TLBWI/TLBWR visible on entries the cycle after accept, and a subsequent TLBP observes it.

Reset
REQ-026 SHALL on rst clear all entries to zero, set random=N-1, wired=0, state=IDLE, resp_valid=0, resp_entry=0, resp_index=0, resp_probe_miss=0.
REQ-027 SHALL abort any in-flight operation on rst with no resp_valid; rst takes priority over every write.

Configuration
REQ-028 SHALL, with TLB_PARALLEL_PROBE_EN defined, compare all entries in the accept cycle and go directly to RESP (TLBP latency 1).
REQ-029 SHALL, without TLB_PARALLEL_PROBE_EN, scan one entry per cycle in PROBE starting at index 0, going to RESP on the first match or after index N-1 (TLBP latency = match index + 2, or N + 1 on a miss).

Structure
REQ-030 SHALL take tlb_entry_t and the op encodings from the shared mmu package; the TLB op constants SHALL be added there.
REQ-031 SHALL place the single-entry match compare in sub-module tlb_entry_match, shared by the serial and parallel probe paths.

Verification
REQ-032 SHALL verify: after reset, random=N-1 and decrements to 0, then wraps to 31 (N=32, wired=0).
REQ-033 SHALL verify: TLBWI index 5 with vpn2=0x12345, asid=3, then TLBR index 5 -> resp_entry equals the written entry, one cycle after accept.
REQ-034 SHALL verify: TLBP with key vpn2=0x12345, asid=3 after REQ-033 -> resp_index=5, miss=0, latency 7 serial or 1 parallel; with asid=4 and G=0 -> miss=1.
REQ-035 SHALL verify: wired_we with wired_wdata=8 together with TLBWR while random=20 -> entry 20 written, next random=31, and random never drops below 8.
REQ-036 SHALL verify: rst asserted during a serial TLBP at scan index 10 -> no resp_valid, req_ready high the cycle after reset deasserts.
REQ-037 SHALL verify: entries 2 and 9 both match a key -> resp_index=2.
